prbs_checker: RTL

PRBS_CHECKER -- requirements
Module: prbs_checker

---
 rtl/prbs_checker.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/prbs_checker.sv
// prbs_checker: serial PRBS receiver check with self-synchronising lock.
// Bits are shifted into a LENGTH-deep history; once LOCK_CNT consecutive
// predictions match, the checker locks and predicts from its own output
// so that each channel error is counted once. Lock is dropped when
// LOSS_THR errors land inside one WINDOW-bit window.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   en       din valid this cycle; all state holds when low
//   din      received serial bit
//   clear    zero err_cnt and bit_cnt (wins over a same-cycle increment)
//   locked   registered, high while the checker is synchronised
//   err      registered one-cycle pulse for a mismatching locked bit
//   err_cnt  saturating count of errors seen while locked
//   bit_cnt  saturating count of bits checked while locked
module prbs_checker #(
  parameter int unsigned       LENGTH   = 16,
  parameter logic [0:LENGTH-1] TAPS     = 16'b0000000000101101,
  parameter int unsigned       LOCK_CNT = 32,
  parameter int unsigned       WINDOW   = 64,
  parameter int unsigned       LOSS_THR = 8,
  parameter int unsigned       CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  input  logic             clear,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] bit_cnt
);

  localparam int unsigned FILL_W  = $clog2(LENGTH + 1);
  localparam int unsigned MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int unsigned WBIT_W  = $clog2(WINDOW + 1);
  localparam int unsigned WERR_W  = $clog2(LOSS_THR + 1);

  typedef enum logic [1:0] {
    S_FILL   = 2'd0,
    S_VERIFY = 2'd1,
    S_LOCKED = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [0:LENGTH-1]  h_q, h_d;
  logic [FILL_W-1:0]  fill_q, fill_d;
  logic [MATCH_W-1:0] match_q, match_d;
  logic [WBIT_W-1:0]  wbit_q, wbit_d;
  logic [WERR_W-1:0]  werr_q, werr_d;
  logic               locked_q, locked_d;
  logic               err_q, err_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;

  logic               pred_c;
  logic               miss_c;
  logic               wrap_c;
  logic [0:LENGTH-1]  h_din_c;
  logic [0:LENGTH-1]  h_pred_c;
  logic [WERR_W-1:0]  werr_inc_c;

  // Prediction from the history; h[0] is the newest bit.
  assign pred_c     = ^(TAPS & h_q);
  assign miss_c     = din ^ pred_c;
  assign h_din_c    = {din, h_q[0:LENGTH-2]};
  assign h_pred_c   = {pred_c, h_q[0:LENGTH-2]};
  assign wrap_c     = (wbit_q == WBIT_W'(WINDOW - 1));
  assign werr_inc_c = werr_q + WERR_W'(1);

  // Next-state and output logic.
  always_comb begin
    state_d   = state_q;
    h_d       = h_q;
    fill_d    = fill_q;
    match_d   = match_q;
    wbit_d    = wbit_q;
    werr_d    = werr_q;
    err_d     = 1'b0;
    err_cnt_d = err_cnt_q;
    bit_cnt_d = bit_cnt_q;

    if (en) begin
      case (state_q)
        S_FILL: begin
          h_d = h_din_c;
          if (fill_q == FILL_W'(LENGTH - 1)) begin
            state_d = S_VERIFY;
            fill_d  = '0;
            match_d = '0;
          end else begin
            fill_d = fill_q + FILL_W'(1);
          end
        end

        S_VERIFY: begin
          h_d = h_din_c;
          // An all-zero history predicts zeros forever, so it never counts.
          if (miss_c || (h_din_c == '0)) begin
            match_d = '0;
          end else if (match_q == MATCH_W'(LOCK_CNT - 1)) begin
            state_d = S_LOCKED;
            match_d = '0;
            wbit_d  = '0;
            werr_d  = '0;
          end else begin
            match_d = match_q + MATCH_W'(1);
          end
        end

        S_LOCKED: begin
          // Feed back the prediction so a corrupted bit never re-enters h.
          h_d    = h_pred_c;
          wbit_d = wrap_c ? '0 : (wbit_q + WBIT_W'(1));
          if (bit_cnt_q != '1) bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (miss_c) begin
            err_d = 1'b1;
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_W'(1);
          end
          if (miss_c && (werr_inc_c == WERR_W'(LOSS_THR))) begin
            state_d = S_FILL;
            fill_d  = '0;
            wbit_d  = '0;
            werr_d  = '0;
          end else if (wrap_c) begin
            werr_d = '0;
          end else if (miss_c) begin
            werr_d = werr_inc_c;
          end
        end

        default: begin
          state_d = S_FILL;
          fill_d  = '0;
        end
      endcase
    end

    if (clear) begin
      err_cnt_d = '0;
      bit_cnt_d = '0;
    end

    locked_d = (state_d == S_LOCKED);
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FILL;
      h_q       <= '0;
      fill_q    <= '0;
      match_q   <= '0;
      wbit_q    <= '0;
      werr_q    <= '0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
      bit_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      h_q       <= h_d;
      fill_q    <= fill_d;
      match_q   <= match_d;
      wbit_q    <= wbit_d;
      werr_q    <= werr_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

  assign locked  = locked_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;
  assign bit_cnt = bit_cnt_q;

endmodule
